// File: rtl/edge_gen_if.sv
// Request/waveform bundle for edge_gen: master drives requests, slave returns waveform and queue status.
interface edge_gen_if #(
  parameter int PEND_W = 3
);
  logic              trig;
  logic              clr_ovf;
  logic              z;
  logic              busy;
  logic [PEND_W-1:0] pend;
  logic              ovf;

  modport master (output trig, clr_ovf, input z, busy, pend, ovf);
  modport slave  (input trig, clr_ovf, output z, busy, pend, ovf);
endinterface

// File: rtl/edge_gen.sv
// Pulse-to-waveform generator: each trig yields HIGH_W high cycles then >= LOW_W low; extra requests queue in pend.
// Latency: trig at edge N -> z high from edge N+1 when idle. No backpressure; saturated queue drops and sets sticky ovf.
// Optional EDGE_GEN_RETRIG_EN: trig during HIGH stretches the current pulse instead of queueing.
module edge_gen #(
  parameter int HIGH_W = 4,
  parameter int LOW_W  = 2,
  parameter int PEND_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  edge_gen_if.slave    io
);
  localparam int CMAX = (HIGH_W > LOW_W) ? HIGH_W : LOW_W;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]     HI_LOAD  = CW'(HIGH_W - 1);
  localparam logic [CW-1:0]     LO_LOAD  = CW'(LOW_W - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              enq;
  logic              drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    enq     = 1'b0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.trig) begin
          state_d = HIGH;
          cnt_d   = HI_LOAD;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = LO_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`ifdef EDGE_GEN_RETRIG_EN
        if (io.trig) begin
          state_d = HIGH;
          cnt_d   = HI_LOAD;
        end
`else
        enq = io.trig;
`endif
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          enq   = io.trig;
        end else if ((pend_q != '0) || io.trig) begin
          // A fresh trig here either starts directly or replaces the dequeued request.
          state_d = HIGH;
          cnt_d   = HI_LOAD;
          if ((pend_q != '0) && !io.trig) begin
            pend_d = pend_q - PEND_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enq) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end

    // A drop in the same cycle as the clear must leave the flag set.
    if (io.clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  assign io.z    = (state_q == HIGH);
  assign io.busy = (state_q != IDLE);
  assign io.pend = pend_q;
  assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_edge_gen.sv
// Randomized and directed bench for edge_gen against a timestamp-based model of the pulse schedule.
module tb_edge_gen;
  localparam int HIGH_W = 4;
  localparam int LOW_W  = 2;
  localparam int PEND_W = 3;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  edge_gen_if #(.PEND_W(PEND_W)) io();

  edge_gen #(.HIGH_W(HIGH_W), .LOW_W(LOW_W), .PEND_W(PEND_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .io  (io)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: pulse schedule kept as absolute cycle stamps. Cycle t's outputs are
  // visible after the edge that starts it; the inputs of cycle t are taken at its closing edge.
  int t;
  bit act;
  int hi_last;
  int mpend;
  bit movf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = 0; mpend = 0; movf = 0; t = 0; hi_last = 0;
    end else begin
      bit tr, clr, dropped, queue_it;
      tr = io.trig; clr = io.clr_ovf; dropped = 0; queue_it = 0;
      if (!act) begin
        if (tr) begin act = 1; hi_last = t + HIGH_W; end
      end else if (t <= hi_last) begin
`ifdef EDGE_GEN_RETRIG_EN
        if (tr) hi_last = t + HIGH_W;
`else
        queue_it = tr;
`endif
      end else if (t < hi_last + LOW_W) begin
        queue_it = tr;
      end else begin
        if (mpend > 0 || tr) begin
          hi_last = t + HIGH_W;
          if (mpend > 0 && !tr) mpend--;
        end else begin
          act = 0;
        end
      end
      if (queue_it) begin
        if (mpend == PMAX) dropped = 1; else mpend++;
      end
      if (clr) movf = 0;
      if (dropped) movf = 1;
      t++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("z",    32'(io.z),    32'(act && (t <= hi_last)));
      chk("busy", 32'(io.busy), 32'(act));
      chk("pend", 32'(io.pend), 32'(mpend));
      chk("ovf",  32'(io.ovf),  32'(movf));
    end
  end

  logic [31:0] z_tr, busy_tr, ovf_tr;
  int pend_tr[32];

  task automatic run_pat(input logic [31:0] tp, input logic [31:0] cp, input int n);
    z_tr = '0; busy_tr = '0; ovf_tr = '0;
    for (int k = 0; k < 32; k++) pend_tr[k] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      z_tr[k]    = io.z;
      busy_tr[k] = io.busy;
      ovf_tr[k]  = io.ovf;
      pend_tr[k] = int'(io.pend);
      #2;
      io.trig    = tp[k];
      io.clr_ovf = cp[k];
    end
    @(negedge clk);
    #2;
    io.trig = 1'b0; io.clr_ovf = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    io.trig = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!io.busy && io.pend == '0) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd1, 32'd0);
    #2; io.clr_ovf = 1'b1;
    @(negedge clk);
    #2; io.clr_ovf = 1'b0;
  endtask

  initial begin
    int dens;
    io.trig = 1'b0; io.clr_ovf = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_z",    32'(io.z),    32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_pend", 32'(io.pend), 32'd0);
    chk("rst_ovf",  32'(io.ovf),  32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // single request
    run_pat(32'h1, 32'h0, 12);
    chk("s1_z", z_tr, 32'h1E);
    chk("s1_busy", busy_tr, 32'h7E);
    drain();

    // three consecutive requests
    run_pat(32'h7, 32'h0, 21);
`ifdef EDGE_GEN_RETRIG_EN
    chk("s2_z", z_tr, 32'h7E);
    chk("s2_busy", busy_tr, 32'h1FE);
`else
    chk("s2_z", z_tr, 32'h1E79E);
    chk("s2_busy", busy_tr, 32'h7FFFE);
    chk("s2_pend3", 32'(pend_tr[3]), 32'd2);
    chk("s2_pend12", 32'(pend_tr[12]), 32'd1);
    chk("s2_pend13", 32'(pend_tr[13]), 32'd0);
`endif
    drain();

`ifndef EDGE_GEN_RETRIG_EN
    // saturation; clear coinciding with a drop at cycle 11, plain clear at 14
    run_pat(32'hFFF, (32'h1 << 11) | (32'h1 << 14), 20);
    chk("s3_ovf", ovf_tr, 32'h7C00);
    chk("s3_pend9", 32'(pend_tr[9]), 32'd7);
    chk("s3_pend12", 32'(pend_tr[12]), 32'd7);
    chk("s3_pend15", 32'(pend_tr[15]), 32'd6);
    drain();
`endif

    // request only in the last gap cycle
    run_pat(32'h41, 32'h0, 16);
    chk("s4_z", z_tr, 32'h79E);
    chk("s4_busy", busy_tr, 32'h1FFE);
    chk("s4_pend7", 32'(pend_tr[7]), 32'd0);
    drain();

    // asynchronous reset mid-pulse
    @(negedge clk); #2 io.trig = 1'b1;
    @(negedge clk); #2 io.trig = 1'b1;
    @(negedge clk); #2 io.trig = 1'b0;
    chk("s5_z_before", 32'(io.z), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s5_z", 32'(io.z), 32'd0);
    chk("s5_busy", 32'(io.busy), 32'd0);
    chk("s5_pend", 32'(io.pend), 32'd0);
    chk("s5_ovf", 32'(io.ovf), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    run_pat(32'h1, 32'h0, 10);
    chk("s5_z_after", z_tr, 32'h1E);
    drain();

    // requests at cycles 0 and 3
    run_pat(32'h9, 32'h0, 14);
`ifdef EDGE_GEN_RETRIG_EN
    chk("s6_z", z_tr, 32'hFE);
    chk("s6_pend4", 32'(pend_tr[4]), 32'd0);
`else
    chk("s6_z", z_tr, 32'h79E);
    chk("s6_pend4", 32'(pend_tr[4]), 32'd1);
`endif
    drain();

    dens = 50;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #2;
      if (c % 200 == 0) dens = int'($urandom_range(5, 95));
      io.trig    = (int'($urandom_range(0, 99)) < dens);
      io.clr_ovf = ($urandom_range(0, 15) == 0);
      rst_n      = ($urandom_range(0, 999) != 0);
    end
    #0 rst_n = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_gen.md
Name: edge_gen

Overview:
- Pulse-to-waveform generator. It is the transmit-side counterpart of the team's edge detector.
- It takes single-cycle request pulses on trig and produces a clean output waveform on z. Each accepted request yields one high pulse of HIGH_W cycles, followed by a guaranteed low gap of at least LOW_W cycles.
- Requests that arrive while a pulse is in progress are queued in a saturating pending counter.
- Sits in front of any consumer that needs well-formed rising/falling edges, including the edge detector itself.

Parameters:
- HIGH_W, 4, cycles z is held high per pulse (legal range: 1 or more).
- LOW_W, 2, minimum cycles z is held low between pulses (legal range: 1 or more).
- PEND_W, 3, width of the pending-request counter (maximum queue depth is 2^PEND_W-1).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- trig  in  1  request; every cycle trig=1 is sampled counts as one request.
- clr_ovf  in  1  synchronous clear of ovf.
- z  out  1  generated waveform.
- busy  out  1  high whenever state is not IDLE.
- pend  out  PEND_W  number of queued, not-yet-started requests.
- ovf  out  1  sticky flag: a request was dropped because pend was saturated.

Behaviour:
- Reset (rst=0), asynchronous: state=IDLE, cnt=0, z=0, busy=0, pend=0, ovf=0. Applies immediately, including in the middle of a pulse.
- z and busy are decoded from registered state only. There is no combinational path from trig to any output.
- FSM states: IDLE, HIGH, GAP. cnt is an internal down-counter sized for max(HIGH_W, LOW_W).
- IDLE: z=0. If trig=1, go to HIGH with cnt=HIGH_W-1; otherwise stay in IDLE. pend is always 0 in IDLE.
- HIGH: z=1. If cnt=0, go to GAP with cnt=LOW_W-1; otherwise decrement cnt.
- GAP: z=0. If cnt>0, decrement cnt. If cnt=0:
  - pend>0 or trig=1: go to HIGH with cnt=HIGH_W-1.
  - otherwise: go to IDLE.
- Request consumption at a GAP to HIGH transition:
  - pend>0 and trig=1: pend is unchanged (trig queued, one request dequeued).
  - pend>0 and trig=0: pend decrements by 1.
  - pend=0 and trig=1: trig is consumed directly; pend stays 0.
- Any trig not consumed (in HIGH, or in GAP with cnt>0) increments pend.
- pend saturation: at 2^PEND_W-1, pend holds and ovf sets on the next edge.
- ovf is sticky. clr_ovf=1 clears it on the next edge. If an overflow occurs in the same cycle as clr_ovf=1, the overflow wins and ovf stays 1.
- Latency: trig sampled at edge N gives z=1 from edge N+1 when the block is IDLE.
- Back-to-back period: exactly HIGH_W+LOW_W cycles, with no IDLE cycle inserted between queued pulses.

Optional Feature:
- Macro: EDGE_GEN_RETRIG_EN.
- Defined: trig=1 while in HIGH reloads cnt=HIGH_W-1, stretching the current pulse, and is not queued. trig in GAP is queued as normal.
- Undefined: trig in HIGH is queued into pend, as described in Behaviour.

Test Plan:
All scenarios use default parameters (HIGH_W=4, LOW_W=2); cycle 0 is the first cycle trig is high.
1. Single trig pulse at cycle 0 -> z=1 in cycles 1-4, z=0 from cycle 5; busy=1 in cycles 1-6, busy=0 at cycle 7; pend stays 0.
2. trig high for cycles 0-2 -> pend=2 at cycle 3; z high in cycles 1-4, 7-10 and 13-16; pend returns to 0 at cycle 13; busy drops at cycle 19.
3. trig held high for 12 cycles -> pend saturates at 7 and ovf=1; trig is then released and clr_ovf pulsed -> ovf=0 on the next edge while pend continues draining.
4. With pend=0, trig pulsed only in the last GAP cycle -> z rises on the next cycle with no IDLE cycle, and pend remains 0.
5. rst driven to 0 at cycle 2 of a pulse -> z=0, busy=0, pend=0 and ovf=0 immediately without waiting for a clock edge; after rst is released, a trig produces a normal pulse.
6. With EDGE_GEN_RETRIG_EN defined, trig at cycles 0 and 3 -> z high in cycles 1-7 (one stretched pulse) and pend stays 0. With the macro undefined, the same stimulus gives z high in cycles 1-4 and 7-10.
